seg7_scanner: RTL

- Downstream consumer of the CYBERcobra core's 32-bit out_o; drives the board's 8-digit common-anode 7-segment display.
- Shows the 32-bit value as 8 hex digits, time-multiplexed one digit per refresh slot.
- Double-buffers the value so a display update never tears mid-scan; supports leading-zero blanking, per-digit enable and decimal points.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scanner_hex_to_seg.sv | 13 +
 rtl/seg7_scanner.sv | 110 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 8-digit common-anode display.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef logic [IDX_W-1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scanner_hex_to_seg.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned double buffering.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW    = 4 * NUM_DIGITS;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  tick, wrap, lz_blank;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    tick      = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    wrap      = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    frame_d   = wrap;

    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load_i) begin
      shadow_d  = data_i;
      pending_d = 1'b1;
    end
    // A load landing on the wrap tick goes straight to disp so it is not held off a whole frame.
    if (wrap) begin
      if (load_i) begin
        disp_d    = data_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end

    nibble   = disp_q[{idx_q, 2'b00} +: 4];
    lz_blank = blank_lz_i && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (digit_en_i[idx_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = lz_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~dp_i[idx_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule
